uart_tx_cfg: RTL

Parametrised UART transmitter, successor to the fixed 8N1 serial transmitter in the video card FPGA. It serialises bytes onto `tx` with compile-time data width and bit period, runtime-selectable parity and stop-bit count, host flow-control blocking, and an optional input FIFO. It sits between the debug/status logic and the board's serial pin.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_cfg.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: frame-state encoding and parity-mode constants shared by the
// uart_tx_cfg transmitter and its optional input FIFO.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Mode 2'b11 is treated the same as PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    case (mode)
      PAR_EVEN, PAR_ODD: return 1'b1;
      PAR_NONE:          return 1'b0;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO that buffers bytes ahead of the transmitter.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with compile-time width/bit period, runtime parity
// and stop-bit selection, and flow-control hold. Define UART_TX_FIFO_EN to add an input FIFO.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 50,
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 tx,
  input  logic                 block,
  output logic                 busy,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 new_data,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 frame_done
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int DW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [DW-1:0] BIT_LAST = DW'(DATA_BITS - 1);

  if (CLK_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_cfg: illegal parameter set");
  end

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;
  logic                 frame_done_q, frame_done_d;
  logic                 block_q;
  logic                 avail;
  logic [DATA_BITS-1:0] din;

`ifdef UART_TX_FIFO_EN
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;

  // The FIFO ignores a pop while empty, so IDLE with no hold is enough.
  assign fifo_pop = (state_q == IDLE) && !block_q;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (new_data && !fifo_full),
    .pop_i   (fifo_pop),
    .wdata_i (data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign avail = !fifo_empty;
  assign din   = fifo_rdata;
  assign busy  = fifo_full;
`else
  logic busy_q;

  assign avail = new_data && !busy_q;
  assign din   = data;
  assign busy  = busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= (state_d != IDLE) || block;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (avail && !block_q) begin
          state_d    = START;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          shift_d    = din;
          par_en_d   = parity_enabled(parity_mode);
          par_bit_d  = (^din) ^ (parity_mode == PAR_ODD);
          stop2_d    = stop2;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (stop_cnt_q == stop2_q) begin
            stop_cnt_d = 1'b0;
            state_d    = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from next-state values so the registered pins line up with state_q.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
    frame_done_d = (state_d == STOP) && (cnt_d == CNT_LAST) && (stop_cnt_d == stop2_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      stop2_q      <= 1'b0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
      block_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_bit_q    <= par_bit_d;
      stop2_q      <= stop2_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
      block_q      <= block;
    end
  end

  assign tx         = tx_q;
  assign frame_done = frame_done_q;

endmodule
